// File: rtl/wave_shaper_pkg.sv
// Shared types and constants for the wave shaper stream block.
package wave_shaper_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  localparam logic [3:0] MODE_PASS = 4'b0001;
  localparam logic [3:0] MODE_TRI  = 4'b0010;
  localparam logic [3:0] MODE_SQR  = 4'b0100;
  localparam logic [3:0] MODE_FM   = 4'b1000;

  // Clamp an integer into [lo, hi].
  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/wave_shaper_stream_fm.sv
// FM toggle generator: derives a toggle period from each sample and flips
// an output bit whenever the per-run position counter reaches that period.
// bit_o presents the updated bit in the same cycle as the enabling sample.
module fm_toggle_gen
  import wave_shaper_pkg::*;
#(
  parameter int W      = 8,
  parameter int FM_MAX = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] sample,
  output logic         bit_o
);

  localparam int SW = W + $clog2(FM_MAX) + 1;

  logic [SW-1:0] prod;
  logic [SW-1:0] step;
  logic [SW-1:0] pos_q, pos_d;
  logic          bit_q, bit_d;

  // Step size: large samples give short periods, zero gives FM_MAX.
  always_comb begin
    prod = SW'(sample) * SW'(FM_MAX);
    step = SW'(FM_MAX) - (prod >> W);
  end

  // Position advance and toggle decision for the current sample.
  always_comb begin
    pos_d = pos_q;
    bit_d = bit_q;
    if (en) begin
      if ((pos_q + SW'(1)) >= step) begin
        bit_d = ~bit_q;
        pos_d = '0;
      end else begin
        pos_d = pos_q + SW'(1);
      end
    end
  end

  assign bit_o = bit_d;

  // Position and bit state; cleared at every accepted run start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      bit_q <= 1'b0;
    end else if (clr) begin
      pos_q <= '0;
      bit_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      bit_q <= bit_d;
    end
  end

endmodule

// File: rtl/wave_shaper_stream.sv
// Streaming waveform shaper: reads DEPTH samples from a 1-cycle-latency
// source RAM and writes the shaped stream (pass, triangle, square, FM) to a
// destination RAM two cycles later at the same address.
// Optional macro WAVE_SHAPER_HYST_EN adds hysteresis to square mode.
module wave_shaper_stream
  import wave_shaper_pkg::*;
#(
  parameter int W         = 8,
  parameter int DEPTH     = 256,
  parameter int TRI_STEP  = 2,
  parameter int SQ_THRESH = 128,
  parameter int FM_MAX    = 20,
  parameter int HYST      = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_flg,
  input  logic [3:0]    sw,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data,
  output logic          busy,
  output logic          rdy_flg
);

  localparam int MAXV = (1 << W) - 1;
`ifdef WAVE_SHAPER_HYST_EN
  localparam int HYST_ON = 1;
`else
  localparam int HYST_ON = 0;
`endif
  localparam int HYST_EFF = HYST * HYST_ON;
  localparam int SQ_HI    = clamp_int(SQ_THRESH + HYST_EFF, 0, MAXV);
  localparam int SQ_LO    = clamp_int(SQ_THRESH - HYST_EFF, 0, MAXV);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q;
  logic [3:0]    mode_q;
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic          busy_q;
  logic          rdy_q;
  logic          drain_q;

  // Read-data alignment stage (sample arriving from the RAM this cycle).
  logic          v1_q;
  logic [AW-1:0] a1_q;

  // Output register.
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [W-1:0]  wr_data_q;

  // Per-run shaping state.
  logic [W-1:0]  tri_val_q, tri_val_d;
  logic [W-1:0]  prev_q, prev_d;
  logic          hyst_q, hyst_d;

  logic          start_acc;
  logic [W-1:0]  tri_next;
  logic          hyst_next;
  logic          sq_bit;
  logic          fm_bit;
  logic          fm_en;
  logic [W-1:0]  shaped;
  int            tri_up, tri_dn;

  assign start_acc = (state_q == ST_IDLE) && start_flg;
  assign fm_en     = v1_q && (mode_q == MODE_FM);

  fm_toggle_gen #(
    .W      (W),
    .FM_MAX (FM_MAX)
  ) u_fm (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_acc),
    .en     (fm_en),
    .sample (rd_data),
    .bit_o  (fm_bit)
  );

  // Run sequencing: read address generation, drain, done, status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      drain_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_flg) begin
            mode_q    <= sw;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rd_addr_q == LAST_ADDR) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            drain_q   <= 1'b0;
            state_q   <= ST_DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + AW'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_q) begin
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            drain_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Triangle and square next values for the sample currently on rd_data.
  always_comb begin
    tri_up = int'(tri_val_q) + TRI_STEP;
    tri_dn = int'(tri_val_q) - TRI_STEP;
    if (a1_q == '0) begin
      tri_next = rd_data;
    end else if (rd_data >= prev_q) begin
      tri_next = (tri_up > MAXV) ? '1 : W'(tri_up);
    end else begin
      tri_next = (tri_dn < 0) ? '0 : W'(tri_dn);
    end

    hyst_next = hyst_q;
`ifdef WAVE_SHAPER_HYST_EN
    if (int'(rd_data) >= SQ_HI) begin
      hyst_next = 1'b1;
    end else if (int'(rd_data) < SQ_LO) begin
      hyst_next = 1'b0;
    end
    sq_bit = hyst_next;
`else
    sq_bit = (int'(rd_data) >= SQ_THRESH + HYST_EFF);
`endif
  end

  // Mode select and per-run state update.
  always_comb begin
    shaped    = '0;
    tri_val_d = tri_val_q;
    prev_d    = prev_q;
    hyst_d    = hyst_q;
    case (mode_q)
      MODE_PASS: shaped = rd_data;
      MODE_TRI:  shaped = tri_next;
      MODE_SQR:  shaped = sq_bit ? '1 : '0;
      MODE_FM:   shaped = fm_bit ? '1 : '0;
      default:   shaped = '0;
    endcase
    if (start_acc) begin
      tri_val_d = '0;
      prev_d    = '0;
      hyst_d    = 1'b0;
    end else if (v1_q) begin
      tri_val_d = tri_next;
      prev_d    = rd_data;
      hyst_d    = hyst_next;
    end
  end

  // Read-latency alignment, output register and shaping state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      a1_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      tri_val_q <= '0;
      prev_q    <= '0;
      hyst_q    <= 1'b0;
    end else begin
      v1_q      <= rd_en_q;
      a1_q      <= rd_addr_q;
      wr_en_q   <= v1_q;
      wr_addr_q <= v1_q ? a1_q : '0;
      wr_data_q <= v1_q ? shaped : '0;
      tri_val_q <= tri_val_d;
      prev_q    <= prev_d;
      hyst_q    <= hyst_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign rdy_flg = rdy_q;

endmodule

// File: tb/tb_wave_shaper_stream.sv
// Self-checking bench for wave_shaper_stream: source RAM model, write
// capture, and a behavioural reference computed per run.
module tb_wave_shaper_stream;
  import wave_shaper_pkg::*;

  localparam int DEPTH = 256;
  localparam int FMMAX = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_flg;
  logic [3:0] sw;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data = '0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       rdy_flg;

  int src  [DEPTH];
  int expv [DEPTH];
  int got  [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  wave_shaper_stream dut (
    .clk       (clk),
    .rst       (rst),
    .start_flg (start_flg),
    .sw        (sw),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .rdy_flg   (rdy_flg)
  );

  always #5 clk = ~clk;

  // Source RAM with one cycle of read latency.
  always @(posedge clk) if (rd_en) rd_data <= 8'(src[rd_addr]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model straight from the shaping rules.
  task automatic build_expected(input logic [3:0] mode);
    int val, pos, b, step, h;
    val = 0; pos = 0; b = 0; h = 0;
    for (int i = 0; i < DEPTH; i++) begin
      case (mode)
        4'b0001: expv[i] = src[i];
        4'b0010: begin
          if (i == 0) val = src[0];
          else if (src[i] >= src[i-1]) val = (val + 2 > 255) ? 255 : val + 2;
          else val = (val - 2 < 0) ? 0 : val - 2;
          expv[i] = val;
        end
        4'b0100: begin
`ifdef WAVE_SHAPER_HYST_EN
          if (src[i] >= 136) h = 1;
          else if (src[i] < 120) h = 0;
          expv[i] = h ? 255 : 0;
`else
          expv[i] = (src[i] >= 128) ? 255 : 0;
`endif
        end
        4'b1000: begin
          step = FMMAX - (src[i] * FMMAX) / 256;
          if (pos + 1 >= step) begin b = 1 - b; pos = 0; end
          else pos = pos + 1;
          expv[i] = b ? 255 : 0;
        end
        default: expv[i] = 0;
      endcase
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) src[i] = int'($urandom_range(0, 255));
  endtask

  // One run, entered and left at a negedge. hold keeps start_flg high and
  // scrambles sw during the run; abort_at>0 asserts rst in that cycle.
  task automatic run(input logic [3:0] mode, input bit hold, input int abort_at, input string tag);
    int first_rd, last_rd, nrd, first_wr, last_wr, nwr, done_k, bad_rd, dup, bad, bad_idx;
    first_rd = -1; last_rd = -1; nrd = 0; first_wr = -1; last_wr = -1; nwr = 0;
    done_k = -1; bad_rd = 0; dup = 0; bad = 0; bad_idx = -1;
    for (int i = 0; i < DEPTH; i++) got[i] = -1;
    build_expected(mode);
    start_flg = 1'b1;
    sw = mode;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, "_busy_c1"}, 32'(busy), 32'd1);
        check({tag, "_rdy_clr_c1"}, 32'(rdy_flg), 32'd0);
        if (!hold) start_flg = 1'b0;
      end
      if (hold) sw = 4'($urandom);
      if (abort_at == k) begin
        check({tag, "_wr_before_rst"}, 32'(wr_en), 32'd1);
        rst = 1'b1;
        #1;
        check({tag, "_rst_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_rdy"}, 32'(rdy_flg), 32'd0);
        start_flg = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      if (rd_en) begin
        nrd++;
        if (first_rd < 0) first_rd = k;
        last_rd = k;
        if (int'(rd_addr) != k - 1) bad_rd++;
      end
      if (wr_en) begin
        nwr++;
        if (first_wr < 0) first_wr = k;
        last_wr = k;
        if (got[wr_addr] != -1) dup++;
        got[wr_addr] = int'(wr_data);
      end
      if (rdy_flg) begin
        done_k = k;
        start_flg = 1'b0;
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        break;
      end
    end
    check({tag, "_done_cycle"}, 32'(done_k), 32'd259);
    check({tag, "_rd_first"}, 32'(first_rd), 32'd1);
    check({tag, "_rd_last"}, 32'(last_rd), 32'd256);
    check({tag, "_rd_count"}, 32'(nrd), 32'd256);
    check({tag, "_rd_addr_seq"}, 32'(bad_rd), 32'd0);
    check({tag, "_wr_first"}, 32'(first_wr), 32'd3);
    check({tag, "_wr_last"}, 32'(last_wr), 32'd258);
    check({tag, "_wr_count"}, 32'(nwr), 32'd256);
    check({tag, "_wr_dup"}, 32'(dup), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (got[i] != expv[i]) begin
        bad++;
        if (bad_idx < 0) bad_idx = i;
      end
    end
    check({tag, "_data_errs"}, 32'(bad), 32'd0);
    if (bad != 0) $display("  %s first bad index %0d got %0d want %0d", tag, bad_idx, got[bad_idx], expv[bad_idx]);
    @(negedge clk);
    check({tag, "_rdy_sticky"}, 32'(rdy_flg), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_flg = 1'b0;
    sw = '0;
    for (int i = 0; i < DEPTH; i++) src[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(rdy_flg), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Pass with ramp source: data equals address.
    for (int i = 0; i < DEPTH; i++) src[i] = i;
    run(MODE_PASS, 1'b0, 0, "pass_ramp");
    for (int i = 0; i < 4; i++) check("pass_ramp_val", 32'(got[i * 85]), 32'(i * 85));

    // Back-to-back start in the IDLE cycle after DONE, random pass.
    fill_random();
    run(MODE_PASS, 1'b0, 0, "pass_rand");

    // Square with directed head, random tail.
    fill_random();
`ifdef WAVE_SHAPER_HYST_EN
    src[0] = 130; src[1] = 140; src[2] = 125; src[3] = 119;
`else
    src[0] = 127; src[1] = 128; src[2] = 255; src[3] = 0;
`endif
    run(MODE_SQR, 1'b0, 0, "square");
    check("square_s0", 32'(got[0]), 32'd0);
    check("square_s1", 32'(got[1]), 32'd255);
    check("square_s2", 32'(got[2]), 32'd255);
    check("square_s3", 32'(got[3]), 32'd0);

    // Triangle with directed head.
    fill_random();
    src[0] = 100; src[1] = 110; src[2] = 105; src[3] = 105; src[4] = 0;
    run(MODE_TRI, 1'b0, 0, "tri");
    check("tri_s0", 32'(got[0]), 32'd100);
    check("tri_s1", 32'(got[1]), 32'd102);
    check("tri_s2", 32'(got[2]), 32'd100);
    check("tri_s3", 32'(got[3]), 32'd102);
    check("tri_s4", 32'(got[4]), 32'd100);

    // Triangle saturation at the top.
    fill_random();
    src[0] = 254; src[1] = 255; src[2] = 255;
    run(MODE_TRI, 1'b0, 0, "tri_sat");
    check("tri_sat_s1", 32'(got[1]), 32'd255);
    check("tri_sat_s2", 32'(got[2]), 32'd255);

    // FM constant 0: slowest toggle.
    for (int i = 0; i < DEPTH; i++) src[i] = 0;
    run(MODE_FM, 1'b0, 0, "fm_zero");
    check("fm_zero_18", 32'(got[18]), 32'd0);
    check("fm_zero_19", 32'(got[19]), 32'd255);
    check("fm_zero_39", 32'(got[39]), 32'd0);

    // FM constant 255: toggle every sample.
    for (int i = 0; i < DEPTH; i++) src[i] = 255;
    run(MODE_FM, 1'b0, 0, "fm_full");
    check("fm_full_0", 32'(got[0]), 32'd255);
    check("fm_full_1", 32'(got[1]), 32'd0);

    // FM random.
    fill_random();
    run(MODE_FM, 1'b0, 0, "fm_rand");

    // start held and sw scrambled mid-run: one run in the original mode.
    fill_random();
    run(MODE_TRI, 1'b1, 0, "hold");
    repeat (3) @(negedge clk);
    check("hold_no_rerun", 32'(busy), 32'd0);

    // Non-one-hot mode gives zero writes.
    fill_random();
    run(4'b0011, 1'b0, 0, "invalid");

    // Abort with reset mid-run, then a clean FM run.
    fill_random();
    run(MODE_FM, 1'b0, 100, "abort");
    check("abort_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) src[i] = 0;
    run(MODE_FM, 1'b0, 0, "post_abort");
    check("post_abort_19", 32'(got[19]), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
